mem_arbiter: RTL and testbench

- Shares the single system memory port (BIOS/RAM dpram) between two requesters: the minx CPU and the PRC video fetch engine that copies framebuffer bytes for scanout.
- Non-pipelined, one transaction in flight.
- CPU has fixed priority; a starvation bound guarantees PRC progress.
- Sits between minx/PRC and the memory; memory read latency is fixed and known.

---
 rtl/pm_mem_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 18 +
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pm_mem_pkg.sv
// Shared types and default widths for the system memory port and its minx/PRC bus glue.
package pm_mem_pkg;

    localparam int AW_DEF = 24;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_PRC
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: CPU has fixed priority unless the PRC is being starved.
module mem_arb_pick
    import pm_mem_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   prc_req_i,
    input  logic   starve_i,
    output owner_t owner_o
);

    always_comb begin
        owner_o = OWN_CPU;
        if (prc_req_i && (!cpu_req_i || starve_i)) begin
            owner_o = OWN_PRC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Non-pipelined arbiter sharing the system memory port between the minx CPU and the PRC
// fetch engine; one transaction in flight, fixed read latency.
module mem_arbiter
    import pm_mem_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int MEM_LAT      = 1,
    parameter int PRC_MAX_WAIT = 4
) (
    input  logic          pclk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          prc_req,
    input  logic          prc_we,
    input  logic [AW-1:0] prc_addr,
    input  logic [DW-1:0] prc_wdata,
    output logic          prc_ack,
    output logic [DW-1:0] prc_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WAIT_W = $clog2(PRC_MAX_WAIT + 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(PRC_MAX_WAIT);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]     prc_rdata_q, prc_rdata_d;
    owner_t            pick;

    mem_arb_pick u_pick (
        .cpu_req_i (cpu_req),
        .prc_req_i (prc_req),
        .starve_i  (wait_q == WAIT_MAX),
        .owner_o   (pick)
    );

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        wait_d      = wait_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        prc_rdata_d = prc_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (!prc_req) begin
                    wait_d = '0;
                end
                if (cpu_req || prc_req) begin
                    owner_d = pick;
                    state_d = ISSUE;
                    if (pick == OWN_PRC) begin
                        mem_addr_d  = prc_addr;
                        mem_we_d    = prc_we;
                        mem_wdata_d = prc_wdata;
                        wait_d      = '0;
                    end else begin
                        mem_addr_d  = cpu_addr;
                        mem_we_d    = cpu_we;
                        mem_wdata_d = cpu_wdata;
                        if (prc_req && wait_q != WAIT_MAX) begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                lat_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    if (owner_q == OWN_PRC) prc_rdata_d = mem_rdata;
                    else                    cpu_rdata_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            lat_q       <= '0;
            wait_q      <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            prc_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            wait_q      <= wait_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            prc_rdata_q <= prc_rdata_d;
        end
    end

    assign cpu_ack   = (state_q == DONE) && (owner_q == OWN_CPU);
    assign prc_ack   = (state_q == DONE) && (owner_q == OWN_PRC);
    assign cpu_rdata = cpu_rdata_q;
    assign prc_rdata = prc_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks, a negedge monitor pops and compares.
module tb_mem_arbiter;

    logic        pclk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        prc_req, prc_we;
    logic [23:0] prc_addr;
    logic [7:0]  prc_wdata;
    logic        prc_ack;
    logic [7:0]  prc_rdata;
    logic [23:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    mem_arbiter #(.AW(24), .DW(8), .MEM_LAT(1), .PRC_MAX_WAIT(4)) dut (
        .pclk      (pclk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .prc_req   (prc_req),
        .prc_we    (prc_we),
        .prc_addr  (prc_addr),
        .prc_wdata (prc_wdata),
        .prc_ack   (prc_ack),
        .prc_rdata (prc_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Memory model: one-cycle registered read; unwritten bytes hold a background pattern.
    logic [7:0] mem [logic [23:0]];
    logic [7:0] rd_q = 8'h00;
    assign mem_rdata = rd_q;

    function automatic logic [7:0] bg(input logic [23:0] a);
        if (a == 24'h001234) return 8'hA5;
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return bg(a);
    endfunction

    always @(posedge pclk) begin
        rd_q <= mem_rd(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit         is_prc;
        logic [7:0] rdata;
        bit         chk_data;
        int         at_cyc;
    } exp_t;

    exp_t sb[$];

    always @(negedge pclk) begin
        if (cpu_ack || prc_ack) begin
            check("dual_ack", 64'(cpu_ack & prc_ack), 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'({cpu_ack, prc_ack}), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_owner", 64'(prc_ack), 64'(e.is_prc));
                check("ack_cycle", 64'(cyc), 64'(e.at_cyc));
                if (e.chk_data)
                    check("ack_rdata", 64'(e.is_prc ? prc_rdata : cpu_rdata), 64'(e.rdata));
            end
        end
    end

    // One transaction from a single requester; when it is alone the grant timing is checked too.
    task automatic run(input bit is_prc, input bit we, input logic [23:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rd, input bit chg_addr);
        int  n;
        bit  got;
        exp_t e;
        @(posedge pclk); #1;
        if (is_prc) begin
            prc_req = 1'b1; prc_we = we; prc_addr = addr; prc_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        n = cyc;
        e.is_prc = is_prc; e.rdata = exp_rd; e.chk_data = !we; e.at_cyc = n + 3;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge pclk);
            if (k == 0) check("idle_we", 64'(mem_we), 64'd0);
            if (k == 1) begin
                check("issue_addr", 64'(mem_addr), 64'(addr));
                check("issue_we", 64'(mem_we), 64'(we));
                check("issue_busy", 64'(busy), 64'd1);
                if (chg_addr) begin
                    if (is_prc) prc_addr = 24'h000020;
                    else        cpu_addr = 24'h000020;
                end
            end
            if (k == 2) begin
                check("wait_addr", 64'(mem_addr), 64'(addr));
                check("wait_we", 64'(mem_we), 64'd0);
            end
            got = is_prc ? prc_ack : cpu_ack;
        end
        check("ack_seen", 64'(got), 64'd1);
        @(posedge pclk); #1;
        if (is_prc) prc_req = 1'b0;
        else        cpu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   acks;
        exp_t e;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        prc_req = 1'b0; prc_we = 1'b0; prc_addr = '0; prc_wdata = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_acks", 64'({cpu_ack, prc_ack}), 64'd0);
        check("rst_busy_we", 64'({busy, mem_we}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_rdata", 64'({mem_wdata, cpu_rdata, prc_rdata}), 64'd0);
        @(posedge pclk); #1;
        reset = 1'b0;
        repeat (5) @(posedge pclk);

        run(1'b0, 1'b0, 24'h001234, 8'h00, 8'hA5, 1'b0);
        run(1'b1, 1'b1, 24'h001000, 8'h3C, 8'h00, 1'b0);
        run(1'b0, 1'b0, 24'h001000, 8'h00, 8'h3C, 1'b0);
        run(1'b1, 1'b0, 24'h000080, 8'h00, 8'hDA, 1'b0);
        run(1'b0, 1'b0, 24'h000010, 8'h00, 8'h4A, 1'b1);

        // Both held: CPU wins four times, then the starved PRC, and the pattern repeats.
        @(posedge pclk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000040;
        prc_req = 1'b1; prc_we = 1'b0; prc_addr = 24'h000080;
        n = cyc;
        for (int k = 0; k < 10; k++) begin
            e.is_prc   = (k == 4) || (k == 9);
            e.rdata    = e.is_prc ? 8'hDA : 8'h1A;
            e.chk_data = 1'b1;
            e.at_cyc   = n + 3 + 4 * k;
            sb.push_back(e);
        end
        acks = 0;
        for (int k = 0; k < 60 && acks < 10; k++) begin
            @(negedge pclk);
            if (cpu_ack || prc_ack) acks++;
        end
        check("contend_acks", 64'(acks), 64'd10);
        @(posedge pclk); #1;
        cpu_req = 1'b0; prc_req = 1'b0;

        // Reset while a CPU read sits in WAIT: no ack, port idle next cycle.
        repeat (2) @(posedge pclk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h001234;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge pclk); #1;
        reset = 1'b0;
        @(negedge pclk);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_we", 64'(mem_we), 64'd0);
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            if (cpu_ack || prc_ack) acks++;
            @(negedge pclk);
        end
        check("rstmid_no_ack", 64'(acks), 64'd0);

        run(1'b0, 1'b0, 24'h001234, 8'h00, 8'hA5, 1'b0);

        repeat (6) @(posedge pclk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
